// File: rtl/skylark_pkg.sv
// Shared core types: register-file geometry, stall counter width and the execute-stage load tag.
package skylark_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned NUM_REGS    = 32;
    localparam int unsigned STALL_CNT_W = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
    } ex_tag_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
        logic [NUM_REGS-1:0] vec;
        vec       = '0;
        vec[addr] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {Width{1'b1}})) begin
            count_d = count_q + {{(Width-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/scoreboard.sv
// Load-use / WAW scoreboard: tracks registers with an outstanding load and stalls decode on hazards.
// Optional SCOREBOARD_WB_BYPASS_EN lets a register being written back this cycle count as ready.
module scoreboard
    import skylark_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   IssueValid_D,
    input  logic [REG_ADDR_W-1:0]  Rs1_D,
    input  logic [REG_ADDR_W-1:0]  Rs2_D,
    input  logic                   Use1_D,
    input  logic                   Use2_D,
    input  logic [REG_ADDR_W-1:0]  Rd_D,
    input  logic                   RdWE_D,
    input  logic                   IsLoad_D,
    input  logic                   Flush_E,
    input  logic                   LoadDone_W,
    input  logic [REG_ADDR_W-1:0]  Rd_W,
    output logic                   Stall_D,
    output logic [NUM_REGS-1:0]    Busy,
    output logic [STALL_CNT_W-1:0] StallCount
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] bypass_mask;
    logic [NUM_REGS-1:0] hazard_vec;
    ex_tag_t             tag_q, tag_d;
    logic                hz_rs1, hz_rs2, hz_rd;
    logic                issue;
    logic                load_issue;

`ifdef SCOREBOARD_WB_BYPASS_EN
    // Register file writes through, so the completing load's value is visible in decode.
    assign bypass_mask = LoadDone_W ? reg_onehot(Rd_W) : '0;
`else
    assign bypass_mask = '0;
`endif

    assign hazard_vec = busy_q & ~bypass_mask;

    assign hz_rs1  = Use1_D & hazard_vec[Rs1_D];
    assign hz_rs2  = Use2_D & hazard_vec[Rs2_D];
    assign hz_rd   = RdWE_D & hazard_vec[Rd_D];
    assign Stall_D = IssueValid_D & (hz_rs1 | hz_rs2 | hz_rd);

    assign issue      = IssueValid_D & ~Stall_D;
    assign load_issue = issue & IsLoad_D & RdWE_D & (Rd_D != '0);

    // Clears first, then the new load's set, so a fresh load wins any same-register collision.
    always_comb begin
        busy_d = busy_q;
        if (LoadDone_W) begin
            busy_d[Rd_W] = 1'b0;
        end
        if (Flush_E && tag_q.valid) begin
            busy_d[tag_q.rd] = 1'b0;
        end
        if (load_issue) begin
            busy_d[Rd_D] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        tag_d.valid = load_issue;
        tag_d.rd    = load_issue ? Rd_D : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            tag_q  <= '0;
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    assign Busy = busy_q;

    sat_counter #(
        .Width (STALL_CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .inc_i   (Stall_D),
        .count_o (StallCount)
    );

endmodule

// File: tb/tb_scoreboard.sv
// Bench for scoreboard: directed scenarios with literal expectations plus a random phase,
// all cross-checked every cycle against a behavioural model of pending loads.
module tb_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        iv, u1, u2, we, isl, fl, ld;
    logic [4:0]  rs1, rs2, rd, rdw;
    logic        Stall_D;
    logic [31:0] Busy;
    logic [15:0] StallCount;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit          busy_m[32];
    bit          tag_v;
    int          tag_rd;
    int          cnt_m;
    bit          st_m;

    always #5 clk = ~clk;

    scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .IssueValid_D (iv),
        .Rs1_D        (rs1),
        .Rs2_D        (rs2),
        .Use1_D       (u1),
        .Use2_D       (u2),
        .Rd_D         (rd),
        .RdWE_D       (we),
        .IsLoad_D     (isl),
        .Flush_E      (fl),
        .LoadDone_W   (ld),
        .Rd_W         (rdw),
        .Stall_D      (Stall_D),
        .Busy         (Busy),
        .StallCount   (StallCount)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit pending(input int r);
        return (r != 0) && busy_m[r] && !(Byp && ld && (int'(rdw) == r));
    endfunction

    function automatic bit exp_stall();
        return iv && ((u1 && pending(int'(rs1))) || (u2 && pending(int'(rs2)))
                      || (we && pending(int'(rd))));
    endfunction

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = busy_m[i];
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
            tag_v = 1'b0;
            tag_rd = 0;
            cnt_m = 0;
        end else begin
            st_m = exp_stall();
            if (st_m && cnt_m < 65535) cnt_m++;
            if (ld && rdw != 0) busy_m[rdw] = 1'b0;
            if (fl && tag_v) busy_m[tag_rd] = 1'b0;
            if (iv && !st_m && isl && we && rd != 0) begin
                busy_m[rd] = 1'b1;
                tag_v = 1'b1;
                tag_rd = int'(rd);
            end else begin
                tag_v = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("stall", {31'd0, Stall_D}, {31'd0, exp_stall()});
        chk("busy", Busy, busy_vec());
        chk("count", {16'd0, StallCount}, cnt_m);
    end

    task automatic idle();
        iv = 0; u1 = 0; u2 = 0; we = 0; isl = 0; fl = 0; ld = 0;
        rs1 = 0; rs2 = 0; rd = 0; rdw = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_load(input logic [4:0] r);
        idle();
        iv = 1; isl = 1; we = 1; rd = r;
    endtask

    task automatic issue_reader(input logic [4:0] r);
        idle();
        iv = 1; u1 = 1; rs1 = r; we = 1; rd = 5'd20;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #1;
        chk("rst_busy", Busy, 32'h0);
        chk("rst_stall", {31'd0, Stall_D}, 32'h0);
        chk("rst_count", {16'd0, StallCount}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        next();

        // Load-use on x5
        issue_load(5'd5);
        @(negedge clk) chk("lu_load_nostall", {31'd0, Stall_D}, 32'h0);
        next();
        issue_reader(5'd5);
        @(negedge clk);
        chk("lu_stall", {31'd0, Stall_D}, 32'h1);
        chk("lu_busy5", Busy, 32'h20);
        repeat (2) begin
            next();
            @(negedge clk) chk("lu_hold", {31'd0, Stall_D}, 32'h1);
        end
        next();
        ld = 1; rdw = 5'd5;
        @(negedge clk) chk("lu_wb_cycle", {31'd0, Stall_D}, Byp ? 32'h0 : 32'h1);
        next();
        ld = 0; rdw = 0;
        @(negedge clk);
        chk("lu_release", {31'd0, Stall_D}, 32'h0);
        chk("lu_count", {16'd0, StallCount}, Byp ? 32'd3 : 32'd4);
        chk("lu_busy_clear", Busy, 32'h0);
        next();

        // x0 is never busy
        issue_load(5'd0);
        next();
        idle();
        iv = 1; u1 = 1; u2 = 1; rs1 = 0; rs2 = 0; we = 1; rd = 0;
        @(negedge clk);
        chk("x0_busy", Busy, 32'h0);
        chk("x0_stall", {31'd0, Stall_D}, 32'h0);
        next();

        // Writeback clear and new load set hit x7 in the same cycle
        issue_load(5'd7);
        ld = 1; rdw = 5'd7;
        next();
        idle();
        @(negedge clk) chk("coll_busy7", Busy, 32'h80);
        next();
        ld = 1; rdw = 5'd7;
        next();
        idle();

        // Flush of the load in execute
        issue_load(5'd9);
        next();
        idle();
        fl = 1;
        @(negedge clk) chk("fl_busy9_pre", Busy, 32'h200);
        next();
        issue_reader(5'd9);
        @(negedge clk);
        chk("fl_busy9", Busy, 32'h0);
        chk("fl_nostall", {31'd0, Stall_D}, 32'h0);
        next();

        // WAW stall, then asynchronous reset mid-stall
        issue_load(5'd3);
        next();
        idle();
        iv = 1; we = 1; rd = 5'd3;
        @(negedge clk) chk("waw_stall", {31'd0, Stall_D}, 32'h1);
        next();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_stall", {31'd0, Stall_D}, 32'h0);
        chk("rst_mid_busy", Busy, 32'h0);
        chk("rst_mid_count", {16'd0, StallCount}, 32'h0);
        next();
        reset = 1'b1;
        idle();
        next();

        // Saturation
        issue_load(5'd4);
        next();
        issue_reader(5'd4);
        repeat (65540) @(posedge clk);
        #1;
        @(negedge clk) chk("sat_ffff", {16'd0, StallCount}, 32'hFFFF);
        next();
        @(negedge clk) chk("sat_nowrap", {16'd0, StallCount}, 32'hFFFF);
        next();
        idle();
        ld = 1; rdw = 5'd4;
        next();
        idle();

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 4000; n++) begin
            iv  = ($urandom_range(0, 3) != 0);
            u1  = $urandom_range(0, 1);
            u2  = $urandom_range(0, 1);
            we  = ($urandom_range(0, 3) != 0);
            isl = ($urandom_range(0, 2) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            ld  = ($urandom_range(0, 2) == 0);
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            rdw = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) begin
                #3 reset = 1'b0;
                #2 reset = 1'b1;
            end
            next();
        end

        idle();
        next();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
